// File: rtl/carbon_arch_pkg.sv
// Shared CarbonZ80 architecture definitions: tier codes, mode-op encoding,
// trap causes, mode-stack frame layout and the mode-request legality check.
package carbon_arch_pkg;

  localparam logic [7:0] CARBON_Z80_DERIVED_TIER_P0_I8080 = 8'd0;
  localparam logic [7:0] CARBON_Z80_DERIVED_TIER_P1_I8085 = 8'd1;
  localparam logic [7:0] CARBON_Z80_DERIVED_TIER_P2_Z80   = 8'd2;

  localparam int CARBON_PC_W = 16;

  typedef enum logic [1:0] {
    OP_NONE   = 2'd0,
    OP_MODEUP = 2'd1,
    OP_RETMD  = 2'd2,
    OP_RSVD   = 2'd3
  } mode_op_e;

  localparam logic [31:0] CAUSE_MODEUP_INVALID  = 32'h0000_0012;
  localparam logic [31:0] CAUSE_RETMD_UNDERFLOW = 32'h0000_0013;
  localparam logic [31:0] CAUSE_MODEOP_ILLEGAL  = 32'h0000_0014;

  typedef struct packed {
    logic [7:0]             tier;
    logic [CARBON_PC_W-1:0] pc;
  } mode_frame_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_TRAP   = 2'd3
  } mode_state_e;

  // Returns 0 for a legal request, otherwise the trap cause (all causes are non-zero).
  function automatic logic [31:0] mode_check(input logic [1:0] op, input logic [7:0] tier,
                                             input logic [7:0] cur, input logic [7:0] max_tier,
                                             input logic full, input logic empty);
    logic [31:0] cause;
    cause = 32'h0;
    case (op)
      OP_MODEUP: begin
        if ((tier > max_tier) || (tier <= cur) || full) cause = CAUSE_MODEUP_INVALID;
        else cause = 32'h0;
      end
      OP_RETMD: begin
        if (empty) cause = CAUSE_RETMD_UNDERFLOW;
        else cause = 32'h0;
      end
      default: cause = CAUSE_MODEOP_ILLEGAL;
    endcase
    return cause;
  endfunction

endpackage

// File: rtl/carbon_mode_stack.sv
// LIFO of {return tier, return PC} frames. No legality checks: the caller
// never pushes when full nor pops when empty.
module carbon_mode_stack
  import carbon_arch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [7:0]                   push_tier,
  input  logic [PC_W-1:0]              push_pc,
  output logic [7:0]                   top_tier,
  output logic [PC_W-1:0]              top_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int FR_W  = 8 + PC_W;

  logic [FR_W-1:0]  mem_q [DEPTH];
  logic [FR_W-1:0]  mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FR_W-1:0]  top_s;

  // Compare-based selects keep index widths independent of DEPTH.
  always_comb begin
    cnt_d = cnt_q;
    top_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (cnt_q == CNT_W'(i + 1)) top_s = mem_q[i];
      if (push && (cnt_q == CNT_W'(i))) mem_d[i] = {push_tier, push_pc};
    end
    if (push) cnt_d = cnt_q + CNT_W'(1);
    else if (pop) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  assign top_tier = top_s[FR_W-1:PC_W];
  assign top_pc   = top_s[PC_W-1:0];
  assign count    = cnt_q;

endmodule

// File: rtl/carbon_mode_ctrl.sv
// CarbonZ80 tier-transition sequencer: validates MODEUP/RETMD, drains the core,
// then commits the new tier and maintains the return-frame stack.
module carbon_mode_ctrl
  import carbon_arch_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int MAX_TIER   = 2,
  parameter int RESET_TIER = 0,
  parameter int PC_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [1:0]                   req_op,
  input  logic [7:0]                   req_tier,
  input  logic [PC_W-1:0]              req_ret_pc,
  output logic                         drain_req,
  input  logic                         drain_done,
  output logic                         rsp_valid,
  output logic [PC_W-1:0]              rsp_pc,
  output logic                         trap_valid,
  output logic [31:0]                  trap_cause,
  output logic [7:0]                   cur_tier,
  output logic [$clog2(DEPTH+1)-1:0]   md_sp
);
  localparam int SP_W = $clog2(DEPTH+1);

  mode_state_e     state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [7:0]      tier_q, tier_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     cause_q, cause_d;
  logic [7:0]      cur_tier_q, cur_tier_d;
  logic            push_s, pop_s;
  logic [31:0]     chk_s;
  logic [7:0]      top_tier_s;
  logic [PC_W-1:0] top_pc_s;
  logic [SP_W-1:0] sp_s;

  carbon_mode_stack #(.DEPTH(DEPTH), .PC_W(PC_W)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .push_tier (cur_tier_q),
    .push_pc   (pc_q),
    .top_tier  (top_tier_s),
    .top_pc    (top_pc_s),
    .count     (sp_s)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    tier_d     = tier_q;
    pc_d       = pc_q;
    cause_d    = cause_q;
    cur_tier_d = cur_tier_q;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    chk_s      = mode_check(req_op, req_tier, cur_tier_q, 8'(MAX_TIER),
                            sp_s == SP_W'(DEPTH), sp_s == '0);
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          tier_d  = req_tier;
          pc_d    = req_ret_pc;
          cause_d = chk_s;
          state_d = (chk_s == 32'h0) ? ST_DRAIN : ST_TRAP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drain_done) state_d = ST_COMMIT;
        else state_d = ST_DRAIN;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (op_q == OP_MODEUP) begin
          push_s     = 1'b1;
          cur_tier_d = tier_q;
        end else begin
          pop_s      = 1'b1;
          cur_tier_d = top_tier_s;
        end
      end
      ST_TRAP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= 2'd0;
      tier_q     <= 8'd0;
      pc_q       <= '0;
      cause_q    <= 32'h0;
      cur_tier_q <= 8'(RESET_TIER);
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      tier_q     <= tier_d;
      pc_q       <= pc_d;
      cause_q    <= cause_d;
      cur_tier_q <= cur_tier_d;
    end
  end

  // All handshake outputs decode straight from the state register.
  assign req_ready  = (state_q == ST_IDLE);
  assign drain_req  = (state_q == ST_DRAIN);
  assign rsp_valid  = (state_q == ST_COMMIT);
  assign trap_valid = (state_q == ST_TRAP);
  assign rsp_pc     = (state_q != ST_COMMIT) ? '0 : ((op_q == OP_MODEUP) ? pc_q : top_pc_s);
  assign trap_cause = (state_q == ST_TRAP) ? cause_q : 32'h0;
  assign cur_tier   = cur_tier_q;
  assign md_sp      = sp_s;

endmodule
